scan_sequencer: RTL
===================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 512, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8, scan address width.
REQ-003 SHALL have parameter DEPTH, default 128, words per memory; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter N_OUT, default 2, output memories dumped; CH_W = max(1, clog2(N_OUT)).
REQ-005 SHALL have parameter RD_LAT, default 1, output-memory read latency in mem_clk cycles (>=1).
REQ-006 SHALL have parameter TIMEOUT_CYC, default 400, RUN watchdog limit.
REQ-007 Ports: reset clk_reset, asynchronous, active-high; clock mem_clk.
REQ-008 start  in  1  pulse; begins a load/run/dump sequence.
REQ-009 in_valid / in_ready  in / out  1  load-stream handshake.
REQ-010 in_data, in_weight  in  DATA_W each  data and weight words for one address.
REQ-011 core_reset  out  1  held reset to conv core.
REQ-012 wen, input_mem_scan_mode  out  1 each  core write enable; input-memory scan select.
REQ-013 output_mem_scan_mode  out  2  00 idle, 01 core-write, 11 scan-read.
REQ-014 scan_addr  out  ADDR_W; data_mem_scan_in, weight_mem_scan_in  out  DATA_W each.
REQ-015 conv_completed  in  1; out_mem_rdata  in  N_OUT*DATA_W, channel c at bits [c*DATA_W +: DATA_W].
REQ-016 out_valid / out_ready  out / in  1; out_data  out  DATA_W; out_chan  out  CH_W; out_addr  out  ADDR_W.
REQ-017 busy, done, timeout  out  1 each  status.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, DUMP_RD, DUMP_EMIT, DONE; all outputs registered.
REQ-019 start SHALL be accepted only in IDLE or DONE -> LOAD; ignored elsewhere.
REQ-020 LOAD: in_ready=1, input_mem_scan_mode=1, core_reset=1; each in_valid&&in_ready beat k SHALL register scan_addr=k and both words next cycle.
REQ-021 After beat DEPTH-1 the FSM SHALL enter RUN one cycle after the last write is presented; scan_addr never wraps.
REQ-022 In_ready SHALL be 0 outside LOAD; in_valid then ignored.
REQ-023 RUN entry: core_reset=0, wen=1, input_mem_scan_mode=0, output_mem_scan_mode=01; stay until conv_completed sampled high.
REQ-024 conv_completed -> DUMP_RD with wen=0, output_mem_scan_mode=11, scan_addr=0.
REQ-025 DUMP_RD SHALL hold scan_addr RD_LAT cycles then capture all N_OUT words into a buffer and enter DUMP_EMIT.
REQ-026 DUMP_EMIT SHALL emit channels 0..N_OUT-1 in order, out_addr=current address; out_data/out_chan/out_addr stable while out_valid&&!out_ready.
REQ-027 After channel N_OUT-1 accepted: address DEPTH-1 -> DONE, else scan_addr+1 -> DUMP_RD.
REQ-028 DONE: done=1, output_mem_scan_mode=00, core_reset stays 0; busy=1 in LOAD..DUMP_EMIT only.
REQ-029 Total dump beats SHALL equal DEPTH*N_OUT, no gaps skipped or repeated under any backpressure.

Reset
REQ-030 clk_reset SHALL asynchronously force IDLE, core_reset=1, all other outputs 0, counters 0, mid-operation included.
REQ-031 First start after reset release SHALL behave identically to a cold start.

Configuration
REQ-032 Macro SCAN_SEQ_TIMEOUT_EN defined: RUN counter; TIMEOUT_CYC cycles without conv_completed -> DUMP_RD, timeout=1 until next start.
REQ-033 Macro undefined: RUN waits indefinitely, timeout tied 0, no counter logic.

Verification
REQ-034 Load DEPTH=128 words, data word k = k -> scan_addr 0..127 with data k each, then RUN entry.
REQ-035 in_valid toggling every other cycle in LOAD -> exactly 128 writes, addresses contiguous.
REQ-036 conv_completed at RUN cycle 50, N_OUT=2, out_ready=1 -> 256 beats, chan 0,1 per addr, done after addr 127.
REQ-037 out_ready low 5 cycles mid-dump -> out_data held, no beat lost or duplicated.
REQ-038 With SCAN_SEQ_TIMEOUT_EN, TIMEOUT_CYC=400, conv_completed never -> DUMP after 400 cycles, timeout=1.
REQ-039 clk_reset pulsed during DUMP_EMIT -> immediate IDLE, core_reset=1; subsequent start completes normally.

Source files
------------

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - load/run/dump sequencer driving a conv core's scan-accessible memories
// Optional RUN watchdog is enabled by defining SCAN_SEQ_TIMEOUT_EN.
module scan_sequencer #(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 128,
  parameter int N_OUT       = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 400,
  localparam int CH_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    mem_clk,
  input  logic                    clk_reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [DATA_W-1:0]       in_weight,
  output logic                    core_reset,
  output logic                    wen,
  output logic                    input_mem_scan_mode,
  output logic [1:0]              output_mem_scan_mode,
  output logic [ADDR_W-1:0]       scan_addr,
  output logic [DATA_W-1:0]       data_mem_scan_in,
  output logic [DATA_W-1:0]       weight_mem_scan_in,
  input  logic                    conv_completed,
  input  logic [N_OUT*DATA_W-1:0] out_mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [CH_W-1:0]         out_chan,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RL_W  = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_RD, DUMP_EMIT, DONE} state_t;

  typedef struct packed {
    logic                    in_ready;
    logic                    core_reset;
    logic                    wen;
    logic                    ism;
    logic [1:0]              osm;
    logic [ADDR_W-1:0]       scan_addr;
    logic [DATA_W-1:0]       data;
    logic [DATA_W-1:0]       weight;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic [CH_W-1:0]         chan;
    logic [ADDR_W-1:0]       out_addr;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        load_cnt;
    logic [RL_W-1:0]         rd_cnt;
    logic [N_OUT*DATA_W-1:0] rd_buf;
  } regs_t;

  state_t          state, state_nxt;
  regs_t           r, r_nxt;
  logic [CH_W-1:0] chan_inc;
  logic            run_expired;

`ifdef SCAN_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] run_cnt;
  logic            timeout_q;

  assign run_expired = (run_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge mem_clk or posedge clk_reset) begin
    if (clk_reset) begin
      run_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
      if ((state == IDLE || state == DONE) && start)
        timeout_q <= 1'b0;
      else if (state == RUN && run_expired && !conv_completed)
        timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign run_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge mem_clk or posedge clk_reset) begin
    if (clk_reset) begin
      state        <= IDLE;
      r            <= '0;
      r.core_reset <= 1'b1;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    chan_inc  = r.chan + 1'b1;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt        = LOAD;
          r_nxt.in_ready   = 1'b1;
          r_nxt.core_reset = 1'b1;
          r_nxt.ism        = 1'b1;
          r_nxt.osm        = 2'b00;
          r_nxt.busy       = 1'b1;
          r_nxt.done       = 1'b0;
          r_nxt.scan_addr  = '0;
          r_nxt.load_cnt   = '0;
        end
      end
      LOAD: begin
        // The extra LOAD cycle after the final beat lets the last write land before RUN.
        if (r.load_cnt == CNT_W'(DEPTH)) begin
          state_nxt        = RUN;
          r_nxt.core_reset = 1'b0;
          r_nxt.wen        = 1'b1;
          r_nxt.ism        = 1'b0;
          r_nxt.osm        = 2'b01;
        end else if (in_valid && r.in_ready) begin
          r_nxt.scan_addr = r.load_cnt[ADDR_W-1:0];
          r_nxt.data      = in_data;
          r_nxt.weight    = in_weight;
          r_nxt.load_cnt  = r.load_cnt + 1'b1;
          r_nxt.in_ready  = (r.load_cnt != CNT_W'(DEPTH - 1));
        end
      end
      RUN: begin
        if (conv_completed || run_expired) begin
          state_nxt       = DUMP_RD;
          r_nxt.wen       = 1'b0;
          r_nxt.osm       = 2'b11;
          r_nxt.scan_addr = '0;
          r_nxt.rd_cnt    = '0;
        end
      end
      DUMP_RD: begin
        if (r.rd_cnt == RL_W'(RD_LAT)) begin
          state_nxt       = DUMP_EMIT;
          r_nxt.rd_buf    = out_mem_rdata;
          r_nxt.out_valid = 1'b1;
          r_nxt.out_data  = out_mem_rdata[DATA_W-1:0];
          r_nxt.chan      = '0;
          r_nxt.out_addr  = r.scan_addr;
        end else begin
          r_nxt.rd_cnt = r.rd_cnt + 1'b1;
        end
      end
      DUMP_EMIT: begin
        if (r.out_valid && out_ready) begin
          if (r.chan == CH_W'(N_OUT - 1)) begin
            r_nxt.out_valid = 1'b0;
            if (r.scan_addr == ADDR_W'(DEPTH - 1)) begin
              state_nxt  = DONE;
              r_nxt.done = 1'b1;
              r_nxt.busy = 1'b0;
              r_nxt.osm  = 2'b00;
            end else begin
              state_nxt       = DUMP_RD;
              r_nxt.scan_addr = r.scan_addr + 1'b1;
              r_nxt.rd_cnt    = '0;
            end
          end else begin
            r_nxt.chan     = chan_inc;
            r_nxt.out_data = r.rd_buf[int'(chan_inc) * DATA_W +: DATA_W];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready             = r.in_ready;
  assign core_reset           = r.core_reset;
  assign wen                  = r.wen;
  assign input_mem_scan_mode  = r.ism;
  assign output_mem_scan_mode = r.osm;
  assign scan_addr            = r.scan_addr;
  assign data_mem_scan_in     = r.data;
  assign weight_mem_scan_in   = r.weight;
  assign out_valid            = r.out_valid;
  assign out_data             = r.out_data;
  assign out_chan             = r.chan;
  assign out_addr             = r.out_addr;
  assign busy                 = r.busy;
  assign done                 = r.done;

endmodule
